// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
// A grant lasts one burst (req_last or MAX_BURST beats); priority rotates past the owner afterwards.
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4,
   localparam int GW       = $clog2(N_REQ),
   localparam int BW       = $clog2(MAX_BURST + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   input  logic [N_REQ-1:0]       req_last,
   output logic [N_REQ-1:0]       req_ready,
   input  logic                   fifo_full,
   output logic                   fifo_write,
   output logic [WIDTH-1:0]       fifo_data,
   output logic [GW-1:0]          grant_id,
   output logic                   busy
);

   // state | meaning
   // IDLE  | no owner; arbitrate among req_valid starting at rr_ptr
   // BURST | grant_id owns the FIFO write port until its burst ends
   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t            state;
   logic [GW-1:0]     rr_ptr;
   logic [BW-1:0]     beat_cnt;

   logic              pick_found;
   logic [GW-1:0]     pick_id;
   logic              owner_valid;
   logic              owner_last;
   logic [WIDTH-1:0]  owner_data;
   logic              xfer;
   logic              burst_end;
   logic [GW-1:0]     next_ptr;

   // Wrapped upward search from rr_ptr; indices >= N_REQ are never formed.
   always_comb begin
      int            idx;
      logic [GW-1:0] idx_v;
      pick_found = 1'b0;
      pick_id    = '0;
      idx        = 0;
      idx_v      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         idx_v = GW'(idx);
         if (!pick_found && req_valid[idx_v]) begin
            pick_found = 1'b1;
            pick_id    = idx_v;
         end
      end
   end

   always_comb begin
      owner_valid = 1'b0;
      owner_last  = 1'b0;
      owner_data  = '0;
      req_ready   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_id == GW'(i)) begin
            owner_valid  = req_valid[i];
            owner_last   = req_last[i];
            owner_data   = req_data[i*WIDTH +: WIDTH];
            req_ready[i] = (state == BURST) && !fifo_full;
         end
      end
   end

   assign xfer       = (state == BURST) && owner_valid && !fifo_full;
   assign fifo_write = xfer;
   assign fifo_data  = xfer ? owner_data : '0;
   assign burst_end  = xfer && (owner_last || (beat_cnt == BW'(MAX_BURST - 1)));
   assign next_ptr   = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + GW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_id <= pick_id;
                  beat_cnt <= '0;
                  state    <= BURST;
                  busy     <= 1'b1;
               end
            end
            BURST: begin
               if (burst_end) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  rr_ptr   <= next_ptr;
                  beat_cnt <= '0;
               end else if (xfer) begin
                  beat_cnt <= beat_cnt + BW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_write;
   logic [7:0]  fifo_data;
   logic [1:0]  grant_id;
   logic        busy;

   int          tests_run;
   int          tests_failed;
   logic [7:0]  wq[$];

   fifo_wr_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .fifo_full  (fifo_full),
      .fifo_write (fifo_write),
      .fifo_data  (fifo_data),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records every beat the FIFO would actually store.
   always @(posedge clk) begin
      if (!reset && fifo_write) wq.push_back(fifo_data);
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic set_beat(input int i, input logic [7:0] d, input logic l);
      req_data[i*8 +: 8] = d;
      req_last[i]        = l;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      cyc();
      #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
      tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
      tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
      tests_run++; if (fifo_write !== 1'b0) begin tests_failed++; $display("FAIL reset_write: got %b expected 0", fifo_write); end
      tests_run++; if (fifo_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", fifo_data); end
      reset = 1'b0;
      cyc();
      #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_no_req_busy: got %b expected 0", busy); end
   endtask

   task automatic test_single();
      logic [7:0] exp_q[$];
      exp_q = '{8'hA1, 8'hA2, 8'hA3};
      wq.delete();
      req_valid = 4'b0100;
      set_beat(2, 8'hA1, 1'b0);
      cyc();
      #1;
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b expected 1", busy); end
      tests_run++; if (grant_id !== 2'd2) begin tests_failed++; $display("FAIL single_grant: got %0d expected 2", grant_id); end
      tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
      tests_run++; if (fifo_write !== 1'b1 || fifo_data !== 8'hA1) begin tests_failed++; $display("FAIL single_beat1: got write=%b data=%h expected write=1 data=a1", fifo_write, fifo_data); end
      cyc();
      set_beat(2, 8'hA2, 1'b0);
      #1;
      tests_run++; if (fifo_data !== 8'hA2) begin tests_failed++; $display("FAIL single_beat2: got %h expected a2", fifo_data); end
      cyc();
      set_beat(2, 8'hA3, 1'b1);
      #1;
      tests_run++; if (fifo_write !== 1'b1) begin tests_failed++; $display("FAIL single_beat3: got %b expected 1", fifo_write); end
      cyc();
      #1;
      tests_run++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin tests_failed++; $display("FAIL single_idle: got busy=%b ready=%b expected busy=0 ready=0000", busy, req_ready); end
      tests_run++; if (wq.size() !== 3) begin tests_failed++; $display("FAIL single_count: got %0d expected 3", wq.size()); end
      for (int i = 0; i < 3 && i < wq.size(); i++) begin
         tests_run++; if (wq[i] !== exp_q[i]) begin tests_failed++; $display("FAIL single_order[%0d]: got %h expected %h", i, wq[i], exp_q[i]); end
      end
      // rr_ptr should now be 3, so requester 3 wins with everyone asking.
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) set_beat(i, 8'h30 + 8'(i), 1'b1);
      cyc();
      #1;
      tests_run++; if (grant_id !== 2'd3 || fifo_data !== 8'h33) begin tests_failed++; $display("FAIL single_rr_next: got grant=%0d data=%h expected grant=3 data=33", grant_id, fifo_data); end
      cyc();
      req_valid = 4'b0000;
      #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_rr_done: got %b expected 0", busy); end
   endtask

   task automatic test_rotation();
      logic [1:0] eg;
      wq.delete();
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) set_beat(i, 8'h10 + 8'(i), 1'b1);
      for (int k = 0; k < 5; k++) begin
         eg = 2'(k % 4);
         cyc();
         #1;
         tests_run++; if (busy !== 1'b1 || grant_id !== eg) begin tests_failed++; $display("FAIL rot_grant[%0d]: got busy=%b grant=%0d expected busy=1 grant=%0d", k, busy, grant_id, eg); end
         tests_run++; if (fifo_write !== 1'b1 || fifo_data !== (8'h10 + 8'(eg))) begin tests_failed++; $display("FAIL rot_data[%0d]: got write=%b data=%h expected write=1 data=%h", k, fifo_write, fifo_data, 8'h10 + 8'(eg)); end
         cyc();
         #1;
         tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rot_release[%0d]: got %b expected 0", k, busy); end
      end
      req_valid = 4'b0000;
      tests_run++; if (wq.size() !== 5) begin tests_failed++; $display("FAIL rot_count: got %0d expected 5", wq.size()); end
   endtask

   task automatic test_burst_cap();
      wq.delete();
      req_valid = 4'b0010;
      set_beat(1, 8'h60, 1'b0);
      cyc();
      for (int b = 0; b < 4; b++) begin
         set_beat(1, 8'h60 + 8'(b), 1'b0);
         #1;
         tests_run++; if (fifo_write !== 1'b1 || fifo_data !== (8'h60 + 8'(b)) || grant_id !== 2'd1) begin tests_failed++; $display("FAIL cap_beat[%0d]: got write=%b data=%h grant=%0d expected write=1 data=%h grant=1", b, fifo_write, fifo_data, grant_id, 8'h60 + 8'(b)); end
         cyc();
      end
      #1;
      tests_run++; if (busy !== 1'b0 || fifo_write !== 1'b0) begin tests_failed++; $display("FAIL cap_release: got busy=%b write=%b expected busy=0 write=0", busy, fifo_write); end
      tests_run++; if (wq.size() !== 4) begin tests_failed++; $display("FAIL cap_count: got %0d expected 4", wq.size()); end
      set_beat(1, 8'h64, 1'b0);
      cyc();
      for (int b = 4; b < 6; b++) begin
         set_beat(1, 8'h60 + 8'(b), (b == 5));
         #1;
         tests_run++; if (busy !== 1'b1 || fifo_write !== 1'b1) begin tests_failed++; $display("FAIL cap_regrant[%0d]: got busy=%b write=%b expected busy=1 write=1", b, busy, fifo_write); end
         cyc();
      end
      #1;
      req_valid = 4'b0000;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL cap_done: got %b expected 0", busy); end
      tests_run++; if (wq.size() !== 6) begin tests_failed++; $display("FAIL cap_total: got %0d expected 6", wq.size()); end
      for (int i = 0; i < 6 && i < wq.size(); i++) begin
         tests_run++; if (wq[i] !== (8'h60 + 8'(i))) begin tests_failed++; $display("FAIL cap_order[%0d]: got %h expected %h", i, wq[i], 8'h60 + 8'(i)); end
      end
   endtask

   task automatic test_full_stall();
      wq.delete();
      req_valid = 4'b0001;
      set_beat(0, 8'h80, 1'b0);
      cyc();
      #1;
      tests_run++; if (grant_id !== 2'd0 || fifo_write !== 1'b1) begin tests_failed++; $display("FAIL stall_first: got grant=%0d write=%b expected grant=0 write=1", grant_id, fifo_write); end
      cyc();
      fifo_full = 1'b1;
      set_beat(0, 8'h81, 1'b0);
      for (int s = 0; s < 3; s++) begin
         #1;
         tests_run++; if (req_ready !== 4'b0000 || fifo_write !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL stall_hold[%0d]: got ready=%b write=%b busy=%b expected ready=0000 write=0 busy=1", s, req_ready, fifo_write, busy); end
         cyc();
      end
      fifo_full = 1'b0;
      for (int b = 1; b < 4; b++) begin
         set_beat(0, 8'h80 + 8'(b), (b == 3));
         #1;
         tests_run++; if (fifo_write !== 1'b1 || fifo_data !== (8'h80 + 8'(b))) begin tests_failed++; $display("FAIL stall_resume[%0d]: got write=%b data=%h expected write=1 data=%h", b, fifo_write, fifo_data, 8'h80 + 8'(b)); end
         cyc();
      end
      #1;
      req_valid = 4'b0000;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL stall_done: got %b expected 0", busy); end
      tests_run++; if (wq.size() !== 4) begin tests_failed++; $display("FAIL stall_count: got %0d expected 4", wq.size()); end
      for (int i = 0; i < 4 && i < wq.size(); i++) begin
         tests_run++; if (wq[i] !== (8'h80 + 8'(i))) begin tests_failed++; $display("FAIL stall_order[%0d]: got %h expected %h", i, wq[i], 8'h80 + 8'(i)); end
      end
   endtask

   task automatic test_owner_gap();
      logic [7:0] exp_q[$];
      exp_q = '{8'hC0, 8'hC1, 8'hC2};
      wq.delete();
      req_valid = 4'b0100;
      set_beat(2, 8'hC0, 1'b0);
      cyc();
      #1;
      tests_run++; if (grant_id !== 2'd2 || fifo_write !== 1'b1) begin tests_failed++; $display("FAIL gap_first: got grant=%0d write=%b expected grant=2 write=1", grant_id, fifo_write); end
      cyc();
      req_valid = 4'b1000;
      set_beat(3, 8'hD0, 1'b0);
      for (int s = 0; s < 2; s++) begin
         #1;
         tests_run++; if (busy !== 1'b1 || grant_id !== 2'd2 || fifo_write !== 1'b0 || req_ready !== 4'b0100) begin tests_failed++; $display("FAIL gap_hold[%0d]: got busy=%b grant=%0d write=%b ready=%b expected busy=1 grant=2 write=0 ready=0100", s, busy, grant_id, fifo_write, req_ready); end
         cyc();
      end
      req_valid = 4'b1100;
      set_beat(2, 8'hC1, 1'b0);
      #1;
      tests_run++; if (fifo_write !== 1'b1 || fifo_data !== 8'hC1) begin tests_failed++; $display("FAIL gap_resume: got write=%b data=%h expected write=1 data=c1", fifo_write, fifo_data); end
      cyc();
      set_beat(2, 8'hC2, 1'b1);
      cyc();
      #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL gap_done: got %b expected 0", busy); end
      tests_run++; if (wq.size() !== 3) begin tests_failed++; $display("FAIL gap_count: got %0d expected 3", wq.size()); end
      for (int i = 0; i < 3 && i < wq.size(); i++) begin
         tests_run++; if (wq[i] !== exp_q[i]) begin tests_failed++; $display("FAIL gap_order[%0d]: got %h expected %h", i, wq[i], exp_q[i]); end
      end
   endtask

   // Requester 3 is still asking from the previous test and is granted next.
   task automatic test_reset_mid_burst();
      cyc();
      #1;
      tests_run++; if (busy !== 1'b1 || grant_id !== 2'd3 || fifo_data !== 8'hD0) begin tests_failed++; $display("FAIL rstmid_grant: got busy=%b grant=%0d data=%h expected busy=1 grant=3 data=d0", busy, grant_id, fifo_data); end
      cyc();
      req_valid = 4'b0000;
      reset     = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      #1;
      tests_run++; if (busy !== 1'b0 || req_ready !== 4'b0000 || fifo_write !== 1'b0) begin tests_failed++; $display("FAIL rstmid_drop: got busy=%b ready=%b write=%b expected busy=0 ready=0000 write=0", busy, req_ready, fifo_write); end
      tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL rstmid_grant_clr: got %0d expected 0", grant_id); end
      req_valid = 4'b1001;
      set_beat(0, 8'hE0, 1'b1);
      set_beat(3, 8'hE3, 1'b1);
      cyc();
      #1;
      tests_run++; if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_data !== 8'hE0) begin tests_failed++; $display("FAIL rstmid_restart: got busy=%b grant=%0d data=%h expected busy=1 grant=0 data=e0", busy, grant_id, fifo_data); end
      cyc();
      req_valid = 4'b0000;
      #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_done: got %b expected 0", busy); end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      req_valid    = 4'b0000;
      req_data     = '0;
      req_last     = 4'b0000;
      fifo_full    = 1'b0;
      test_reset();
      test_single();
      test_rotation();
      test_burst_cap();
      test_full_stall();
      test_owner_gap();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
